dram_seq: RTL and testbench

- Parametrised successor to the combinational DRAM decoder: a clocked sequencer for the 68040 bus that drives multiplexed-address FPM DRAM.
- Decodes the DRAM window, latches the transfer on nTS and runs RAS/CAS/precharge timing with programmable cycle counts.
- Acknowledges the CPU with nTA and inserts CAS-before-RAS refresh.
- Sits between the 68040 bus interface and the SIMM banks; supports N banks and configurable row/column width.

---
 rtl/dram_seq.sv | 206 ++++++++++++++++++++
 tb/tb_dram_seq.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_seq.sv
// dram_seq: clocked 68040-to-FPM-DRAM sequencer with programmable RAS/CAS/precharge timing and CBR refresh.
// Optional macro DRAM_SEQ_BURST_EN turns line (SIZ=11) transfers into 4-beat page-mode bursts.
module dram_seq #(
  parameter int         ROW_W       = 12,
  parameter int         COL_W       = 12,
  parameter int         NBANKS      = 4,
  parameter logic [2:0] DRAM_BASE   = 3'b001,
  parameter int         RAS_CYC     = 2,
  parameter int         CAS_CYC     = 2,
  parameter int         PRE_CYC     = 2,
  parameter int         REFRESH_DIV = 780,
  localparam int        MA_W        = (ROW_W > COL_W) ? ROW_W : COL_W
) (
  input  logic              CLK,
  input  logic              nRESET,
  input  logic [31:0]       A,
  input  logic [1:0]        SIZ,
  input  logic              RnW,
  input  logic              nTS,
  output logic [MA_W-1:0]   MA,
  output logic [NBANKS-1:0] nRAS,
  output logic [3:0]        nCAS,
  output logic              nWE,
  output logic              nTA,
  output logic              busy
);

  localparam int BANK_W   = $clog2(NBANKS);
  localparam int BANK_LSB = COL_W + 2;
  localparam int ROW_LSB  = COL_W + 2 + BANK_W;
  localparam int MAX_CYC  = (RAS_CYC > CAS_CYC) ? ((RAS_CYC > PRE_CYC) ? RAS_CYC : PRE_CYC)
                                                : ((CAS_CYC > PRE_CYC) ? CAS_CYC : PRE_CYC);
  localparam int CNT_W    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int RCNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  localparam logic [CNT_W-1:0]  RAS_LAST = CNT_W'(RAS_CYC - 1);
  localparam logic [CNT_W-1:0]  CAS_LAST = CNT_W'(CAS_CYC - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(PRE_CYC - 1);
  localparam logic [RCNT_W-1:0] REF_LAST = RCNT_W'(REFRESH_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, ROW, COL, ACK, PRE, REF_CAS, REF_RAS, CPAGE
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt;
  logic [RCNT_W-1:0]  ref_cnt;
  logic               ref_pending, req_pending;
  logic [COL_W-1:0]   req_col;
  logic [BANK_W-1:0]  req_bank;
  logic [ROW_W-1:0]   req_row;
  logic [3:0]         req_lanes;
  logic               req_rnw;
  logic [COL_W-1:0]   col_cur;
  logic               line_more;
  logic               hit, capture, ref_tick, ref_enter, ack_done;

  // Enabled byte lanes, bit 3 = D31:24 (byte offset 0)
  function automatic logic [3:0] lane_mask(input logic [1:0] a_lo, input logic [1:0] siz);
    case (siz)
      2'b01:   lane_mask = 4'b1000 >> a_lo;
      2'b10:   lane_mask = a_lo[1] ? 4'b0011 : 4'b1100;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  assign hit       = (A[31:29] == DRAM_BASE);
  assign capture   = !nTS && hit;
  assign ref_tick  = (ref_cnt == REF_LAST);
  assign ref_enter = (state == IDLE) && (state_next == REF_CAS);
  assign ack_done  = (state == ACK) && (state_next == PRE);

`ifdef DRAM_SEQ_BURST_EN
  logic       req_line;
  logic [1:0] beat;

  // Page-mode column walks the low two bits with wrap-around
  assign col_cur   = {req_col[COL_W-1:2], req_col[1:0] + beat};
  assign line_more = req_line && (beat != 2'd3);

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      beat     <= '0;
      req_line <= 1'b0;
    end else begin
      if (capture)
        req_line <= (SIZ == 2'b11);
      if (state == IDLE)
        beat <= '0;
      else if (state == ACK)
        beat <= beat + 2'd1;
    end
  end
`else
  assign col_cur   = req_col;
  assign line_more = 1'b0;
`endif

  // A fresh capture wins over the clear at ACK so a back-to-back request is never lost
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      req_pending <= 1'b0;
      req_col     <= '0;
      req_bank    <= '0;
      req_row     <= '0;
      req_lanes   <= '0;
      req_rnw     <= 1'b1;
    end else if (capture) begin
      req_pending <= 1'b1;
      req_col     <= A[COL_W+1:2];
      req_bank    <= A[BANK_LSB +: BANK_W];
      req_row     <= A[ROW_LSB +: ROW_W];
      req_lanes   <= lane_mask(A[1:0], SIZ);
      req_rnw     <= RnW;
    end else if (ack_done) begin
      req_pending <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
    end else begin
      ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
      if (ref_tick)
        ref_pending <= 1'b1;
      else if (ref_enter)
        ref_pending <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state || state == IDLE) ? '0 : cnt + 1'b1;
    end
  end

  // Strobes decode straight from the state so reset releases them in the same cycle
  always_comb begin
    state_next = state;
    MA         = '0;
    nRAS       = '1;
    nCAS       = '1;
    nWE        = 1'b1;
    nTA        = 1'b1;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (ref_pending)
          state_next = REF_CAS;
        else if (req_pending)
          state_next = ROW;
      end
      ROW: begin
        MA             = MA_W'(req_row);
        nRAS[req_bank] = 1'b0;
        nWE            = req_rnw;
        if (cnt == RAS_LAST)
          state_next = COL;
      end
      COL: begin
        MA             = MA_W'(col_cur);
        nRAS[req_bank] = 1'b0;
        nCAS           = ~req_lanes;
        nWE            = req_rnw;
        if (cnt == CAS_LAST)
          state_next = ACK;
      end
      ACK: begin
        MA             = MA_W'(col_cur);
        nRAS[req_bank] = 1'b0;
        nCAS           = ~req_lanes;
        nWE            = req_rnw;
        nTA            = 1'b0;
        state_next     = line_more ? CPAGE : PRE;
      end
      CPAGE: begin
        MA             = MA_W'(col_cur);
        nRAS[req_bank] = 1'b0;
        nWE            = req_rnw;
        state_next     = COL;
      end
      PRE: begin
        if (cnt == PRE_LAST)
          state_next = IDLE;
      end
      REF_CAS: begin
        nCAS       = '0;
        state_next = REF_RAS;
      end
      REF_RAS: begin
        nRAS = '0;
        nCAS = '0;
        if (cnt == RAS_LAST)
          state_next = PRE;
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dram_seq.sv
// tb_dram_seq: randomized scoreboard bench for dram_seq; expected acks come from a transaction-level model.
// Define DRAM_SEQ_BURST_EN for both bench and RTL to also exercise 4-beat line bursts.
module tb_dram_seq;

  localparam int ROW_W   = 12;
  localparam int COL_W   = 12;
  localparam int NBANKS  = 4;
  localparam int REF_DIV = 16;

  logic        CLK    = 1'b0;
  logic        nRESET = 1'b0;
  logic [31:0] A      = '0;
  logic [1:0]  SIZ    = '0;
  logic        RnW    = 1'b1;
  logic        nTS    = 1'b1;
  logic [11:0] MA;
  logic [3:0]  nRAS;
  logic [3:0]  nCAS;
  logic        nWE;
  logic        nTA;
  logic        busy;

  dram_seq #(
    .ROW_W(ROW_W), .COL_W(COL_W), .NBANKS(NBANKS), .DRAM_BASE(3'b001),
    .RAS_CYC(2), .CAS_CYC(2), .PRE_CYC(2), .REFRESH_DIV(REF_DIV)
  ) dut (
    .CLK(CLK), .nRESET(nRESET), .A(A), .SIZ(SIZ), .RnW(RnW), .nTS(nTS),
    .MA(MA), .nRAS(nRAS), .nCAS(nCAS), .nWE(nWE), .nTA(nTA), .busy(busy)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [11:0] ma;
    logic [3:0]  ncas;
    logic [3:0]  nras;
    logic        nwe;
  } resp_t;

  resp_t       exp_q[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned cyc;

  // Rising edges since reset release; refresh ticks land on multiples of REF_DIV
  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] lane_ncas(input logic [31:0] a, input logic [1:0] siz);
    logic [3:0] ncas;
    int first;
    int n;
    ncas  = 4'hF;
    first = 0;
    n     = 4;
    if (siz == 2'b01) begin
      first = int'(a[1:0]);
      n     = 1;
    end else if (siz == 2'b10) begin
      first = a[1] ? 2 : 0;
      n     = 2;
    end
    for (int o = first; o < first + n; o++) ncas[3-o] = 1'b0;
    return ncas;
  endfunction

  // Called just after a falling edge; holds nTS low for one cycle and queues the expected acks
  task automatic applyStimulus(input logic [31:0] a, input logic [1:0] siz, input logic rnw);
    int col;
    int bank;
    int beats;
    A   = a;
    SIZ = siz;
    RnW = rnw;
    nTS = 1'b0;
    if (a[31:29] == 3'b001) begin
      col   = int'((a >> 2) % 4096);
      bank  = int'((a >> 14) % 4);
      beats = 1;
`ifdef DRAM_SEQ_BURST_EN
      if (siz == 2'b11) beats = 4;
`endif
      for (int i = 0; i < beats; i++) begin
        resp_t r;
        r.ma   = 12'((col & ~3) | ((col + i) & 3));
        r.ncas = lane_ncas(a, siz);
        r.nras = ~(4'b0001 << bank);
        r.nwe  = rnw;
        exp_q.push_back(r);
      end
    end
    @(negedge CLK);
    nTS = 1'b1;
    A   = $urandom();
  endtask

  // Every nTA must match the oldest outstanding expected beat
  always @(negedge CLK) begin
    if (nRESET === 1'b1 && nTA === 1'b0) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_nta", nTA, 1'b1);
      end else begin
        resp_t e;
        e = exp_q.pop_front();
        checkOutput("ack_bus", {MA, nCAS, nRAS, nWE}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          n;
    int unsigned k;
    int unsigned m0;
    logic [31:0] r;

    repeat (3) @(negedge CLK);
    checkOutput("rst_nras", nRAS, 4'hF);
    checkOutput("rst_ncas", nCAS, 4'hF);
    checkOutput("rst_nwe",  nWE,  1'b1);
    checkOutput("rst_nta",  nTA,  1'b1);
    checkOutput("rst_ma",   MA,   12'h0);
    checkOutput("rst_busy", busy, 1'b0);

    nRESET = 1'b1;
    applyStimulus(32'h2000_0010, 2'b00, 1'b1);
    n = 0;
    while (nRAS === 4'hF && n < 20) begin @(negedge CLK); n++; end
    checkOutput("midrow_reached_row", nRAS, 4'b1110);
    #2 nRESET = 1'b0;
    #1;
    checkOutput("midrow_nras", nRAS, 4'hF);
    checkOutput("midrow_ncas", nCAS, 4'hF);
    checkOutput("midrow_nta",  nTA,  1'b1);
    checkOutput("midrow_busy", busy, 1'b0);
    exp_q.delete();
    @(negedge CLK);
    nRESET = 1'b1;
    repeat (12) @(negedge CLK);
    checkOutput("midrow_idle_after", busy, 1'b0);

    nRESET = 1'b0;
    @(negedge CLK);
    nRESET = 1'b1;

    k = cyc + 1;
    applyStimulus(32'h2000_4008, 2'b00, 1'b1);
    for (int d = 0; d <= 8; d++) begin
      if (d > 0) @(negedge CLK);
      case (d)
        0: checkOutput("lr_nras_k", nRAS, 4'hF);
        1: begin
          checkOutput("lr_nras_k1", nRAS, 4'b1101);
          checkOutput("lr_ma_row", MA, 12'h000);
        end
        2: checkOutput("lr_ncas_k2", nCAS, 4'hF);
        3: begin
          checkOutput("lr_ncas_k3", nCAS, 4'h0);
          checkOutput("lr_ma_col", MA, 12'h002);
        end
        4: checkOutput("lr_nta_k4", nTA, 1'b1);
        5: checkOutput("lr_nta_k5", nTA, 1'b0);
        6: checkOutput("lr_nta_k6", nTA, 1'b1);
        7: checkOutput("lr_busy_pre", busy, 1'b1);
        default: checkOutput("lr_busy_idle", busy, 1'b0);
      endcase
    end
    checkOutput("lr_cycle_align", cyc, k + 8);

    applyStimulus(32'h2000_0003, 2'b01, 1'b0);
    n = 0;
    while (nRAS === 4'hF && n < 20) begin @(negedge CLK); n++; end
    checkOutput("bw_nwe_row", nWE, 1'b0);
    n = 0;
    while (nTA !== 1'b0 && n < 20) begin @(negedge CLK); n++; end
    checkOutput("bw_nta_seen", nTA, 1'b0);
    @(negedge CLK);
    checkOutput("bw_nwe_pre", nWE, 1'b1);
    checkOutput("bw_ncas_pre", nCAS, 4'hF);

    n = 0;
    while (!((cyc % REF_DIV) == 7 && busy === 1'b0) && n < 40) begin @(negedge CLK); n++; end
    checkOutput("miss_setup_idle", busy, 1'b0);
    applyStimulus(32'h4000_0000, 2'b00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checkOutput("miss_busy", busy, 1'b0);
      checkOutput("miss_nras", nRAS, 4'hF);
    end

    n = 0;
    while (!(((cyc + 1) % REF_DIV) == 0 && busy === 1'b0) && n < 40) begin @(negedge CLK); n++; end
    checkOutput("refcol_setup_idle", busy, 1'b0);
    m0 = cyc + 1;
    applyStimulus(32'h2000_0100, 2'b00, 1'b1);
    @(negedge CLK);
    checkOutput("refcol_cycle", cyc, m0 + 1);
    checkOutput("ref_cas_ncas", nCAS, 4'h0);
    checkOutput("ref_cas_nras", nRAS, 4'hF);
    @(negedge CLK);
    checkOutput("ref_ras_nras", nRAS, 4'h0);
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(negedge CLK); n++; end
    checkOutput("refcol_access_done", exp_q.size(), 0);

`ifdef DRAM_SEQ_BURST_EN
    n = 0;
    while (busy !== 1'b0 && n < 40) begin @(negedge CLK); n++; end
    applyStimulus(32'h2000_0008, 2'b11, 1'b1);
    for (int b = 0; b < 4; b++) begin
      n = 0;
      while (nTA !== 1'b0 && n < 40) begin @(negedge CLK); n++; end
      checkOutput("burst_nta", nTA, 1'b0);
      @(negedge CLK);
      if (b < 3) checkOutput("burst_gap_ncas", nCAS, 4'hF);
      checkOutput("burst_gap_nta", nTA, 1'b1);
    end
`endif

    for (int i = 0; i < 40; i++) begin
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin @(negedge CLK); n++; end
      checkOutput("rand_drain", exp_q.size(), 0);
      repeat ($urandom_range(1, 3)) @(negedge CLK);
      r = $urandom();
      if ($urandom_range(0, 3) != 0) r[31:29] = 3'b001;
      else if (r[31:29] == 3'b001) r[31:29] = 3'b110;
      applyStimulus(r, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    n = 0;
    while (exp_q.size() != 0 && n < 300) begin @(negedge CLK); n++; end
    repeat (20) @(negedge CLK);
    checkOutput("final_queue", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
